// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I-subset control FSM
//
// Purpose:
//   Sequences a multicycle datapath through fetch, decode, memory, execute,
//   writeback, branch and jal states. It decodes the datapath control fields
//   from the current state and instruction fields with no added latency.
//   Unsupported opcodes (and unsupported branch funct3) park the machine in
//   TRAP until reset.
//
// Parameters:
//   MEM_WAIT   1: FETCH/MEMREAD/MEMWRITE stall until mem_ready; 0: never stall
//   BR_EXT     1: bne (funct3=001) accepted on the branch opcode as well as beq
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   Op         opcode from the instruction register
//   funct3     funct3 field
//   funct7     funct7 field (only bit 5 is meaningful)
//   Zero       ALU zero flag
//   mem_ready  memory completes the current access this cycle
//   PCWrite    PC write enable
//   IRWrite    instruction register write enable
//   MemWrite   data memory write enable
//   RegWrite   register file write enable
//   AdrSrc     memory address select (0=PC, 1=ALUOut)
//   ResultSrc  result mux select
//   ALUSrcA    ALU A operand select
//   ALUSrcB    ALU B operand select
//   ImmSrc     immediate format select
//   ALUControl ALU operation
//   state_o    current state code
//   illegal    high while in TRAP
//   retire     one-cycle pulse when an instruction completes

module multicycle_control_unit #(
    parameter bit MEM_WAIT = 1'b1,
    parameter bit BR_EXT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state_o,
    output logic       illegal,
    output logic       retire
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // With MEM_WAIT=0 the memory is assumed to always complete in one cycle.
    logic rdy;
    assign rdy = MEM_WAIT ? mem_ready : 1'b1;

    logic is_beq;
    logic br_ok;
    assign is_beq = (funct3 == 3'b000);
    assign br_ok  = is_beq | (BR_EXT & (funct3 == 3'b001));

    // Only funct7[5] distinguishes sub from add; the rest is don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = br_ok ? S_BRANCH : S_TRAP;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // The opcode should still be lw/sw here; anything else means
                // the instruction register changed under us, so trap.
                if (Op == OP_LW)      state_d = S_MEMREAD;
                else if (Op == OP_SW) state_d = S_MEMWRITE;
                else                  state_d = S_TRAP;
            end
            S_MEMREAD: begin
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (rdy) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_ALUWB, S_BRANCH:       state_d = S_FETCH;
            S_TRAP:                  state_d = S_TRAP;
            default:                 state_d = S_FETCH;
        endcase
    end

    // ---------------------------------------------------- per-state decode
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch_en;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       retire_raw;
    logic       illegal_raw;

    always_comb begin
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch_en     = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = rdy;
                pc_update    = rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = rdy;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                branch_en  = 1'b1;
                retire_raw = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_TRAP: begin
                illegal_raw = 1'b1;
            end
            default: begin
                alu_op = 2'b00;
            end
        endcase
    end

    // Side-effecting strobes are forced low during reset so a reset landing
    // mid-instruction cannot write memory, registers or the PC.
    assign PCWrite  = ~rst & (pc_update | (branch_en & (is_beq ? Zero : ~Zero)));
    assign IRWrite  = ~rst & ir_write_raw;
    assign MemWrite = ~rst & mem_write_raw;
    assign RegWrite = ~rst & reg_write_raw;
    assign retire   = ~rst & retire_raw;
    assign illegal  = ~rst & illegal_raw;
    assign state_o  = state_q;

    // -------------------------------------------------------- ALU decoder
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    // sub only for R-type (Op[5]=1); addi never subtracts
                    3'b000:  ALUControl = (Op[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    // ---------------------------------------------------- immediate select
    always_comb begin
        case (Op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            default: ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;
    localparam logic [6:0] OP_SYS = 7'h73;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [6:0] op = OP_R;
    logic [2:0] f3 = 3'd0;
    logic [6:0] f7 = 7'd0;
    logic       zero = 1'b0;
    logic       mr = 1'b1;

    logic       pcw [2];
    logic       irw [2];
    logic       mwr [2];
    logic       rgw [2];
    logic       adr [2];
    logic [1:0] rs  [2];
    logic [1:0] sa  [2];
    logic [1:0] sb  [2];
    logic [2:0] imm [2];
    logic [2:0] aluc[2];
    logic [3:0] st  [2];
    logic       ill [2];
    logic       ret [2];

    // dut0: stalling memory, beq only; dut1: no memory stall, bne allowed
    multicycle_control_unit #(.MEM_WAIT(1'b1), .BR_EXT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .Op(op), .funct3(f3), .funct7(f7), .Zero(zero),
        .mem_ready(mr), .PCWrite(pcw[0]), .IRWrite(irw[0]), .MemWrite(mwr[0]),
        .RegWrite(rgw[0]), .AdrSrc(adr[0]), .ResultSrc(rs[0]), .ALUSrcA(sa[0]),
        .ALUSrcB(sb[0]), .ImmSrc(imm[0]), .ALUControl(aluc[0]), .state_o(st[0]),
        .illegal(ill[0]), .retire(ret[0]));

    multicycle_control_unit #(.MEM_WAIT(1'b0), .BR_EXT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .Op(op), .funct3(f3), .funct7(f7), .Zero(zero),
        .mem_ready(mr), .PCWrite(pcw[1]), .IRWrite(irw[1]), .MemWrite(mwr[1]),
        .RegWrite(rgw[1]), .AdrSrc(adr[1]), .ResultSrc(rs[1]), .ALUSrcA(sa[1]),
        .ALUSrcB(sb[1]), .ImmSrc(imm[1]), .ALUControl(aluc[1]), .state_o(st[1]),
        .illegal(ill[1]), .retire(ret[1]));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: per-state operand/result selections, indexed by state code.
    int A_T   [12] = '{0, 1, 2, 0, 0, 0, 2, 2, 0, 2, 1, 0};
    int B_T   [12] = '{2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0};
    int RS_T  [12] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    int AOP_T [12] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 0, 0};
    bit MW_P  [2]  = '{1'b1, 1'b0};
    bit BX_P  [2]  = '{1'b0, 1'b1};

    int m_st [2] = '{-1, -1};   // -1: state unknown until first reset edge

    function automatic logic [22:0] model_out(int s, bit mw, bit bx, bit r,
        logic [6:0] o, logic [2:0] f, logic [6:0] f7v, bit z, bit m);
        bit rdy, pcw_e, irw_e, mw_e, rw_e, ad_e, il_e, rt_e;
        logic [2:0] ac, im;
        int aop;
        rdy   = mw ? m : 1'b1;
        pcw_e = (s == 0 && rdy) || s == 10 || (s == 9 && ((f == 0) ? z : !z));
        irw_e = (s == 0 && rdy);
        mw_e  = (s == 5);
        rw_e  = (s == 4 || s == 8);
        ad_e  = (s == 3 || s == 5);
        il_e  = (s == 11);
        rt_e  = (s == 4 || s == 8 || s == 9 || (s == 5 && rdy));
        if (r) begin
            pcw_e = 0; irw_e = 0; mw_e = 0; rw_e = 0; il_e = 0; rt_e = 0;
        end
        aop = AOP_T[s];
        if (aop == 0)      ac = 3'd0;
        else if (aop == 1) ac = 3'd1;
        else if (f == 0)   ac = (o[5] && f7v[5]) ? 3'd1 : 3'd0;
        else if (f == 2)   ac = 3'd5;
        else if (f == 6)   ac = 3'd3;
        else if (f == 7)   ac = 3'd2;
        else               ac = 3'd0;
        if (o == OP_SW)       im = 3'd1;
        else if (o == OP_BR)  im = 3'd2;
        else if (o == OP_JAL) im = 3'd3;
        else                  im = 3'd0;
        if (bx) begin end
        return {pcw_e, irw_e, mw_e, rw_e, ad_e, 2'(RS_T[s]), 2'(A_T[s]), 2'(B_T[s]),
                im, ac, 4'(s), il_e, rt_e};
    endfunction

    function automatic int model_next(int s, bit mw, bit bx, bit r,
        logic [6:0] o, logic [2:0] f, bit m);
        bit rdy;
        rdy = mw ? m : 1'b1;
        if (r) return 0;
        case (s)
            0: return rdy ? 1 : 0;
            1: begin
                if (o == OP_LW || o == OP_SW) return 2;
                if (o == OP_R)   return 6;
                if (o == OP_I)   return 7;
                if (o == OP_BR)  return (f == 0 || (bx && f == 1)) ? 9 : 11;
                if (o == OP_JAL) return 10;
                return 11;
            end
            2: return (o == OP_LW) ? 3 : (o == OP_SW) ? 5 : 11;
            3: return rdy ? 4 : 3;
            5: return rdy ? 0 : 5;
            6, 7, 10: return 8;
            11: return 11;
            default: return 0;
        endcase
    endfunction

    function automatic logic [22:0] dut_vec(int i);
        return {pcw[i], irw[i], mwr[i], rgw[i], adr[i], rs[i], sa[i], sb[i],
                imm[i], aluc[i], st[i], ill[i], ret[i]};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // One cycle: drive inputs away from the edge, compare both DUTs to the
    // model, then advance the model to the state after the coming edge.
    task automatic step(input bit r, input logic [6:0] o, input logic [2:0] f,
                        input logic [6:0] f7v, input bit z, input bit m);
        logic [22:0] e;
        @(negedge clk);
        rst = r; op = o; f3 = f; f7 = f7v; zero = z; mr = m;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (m_st[i] >= 0) begin
                e = model_out(m_st[i], MW_P[i], BX_P[i], r, o, f, f7v, z, m);
                chk(i == 0 ? "dut0 outputs" : "dut1 outputs", int'(dut_vec(i)), int'(e));
            end
        end
        for (int i = 0; i < 2; i++)
            m_st[i] = model_next(m_st[i], MW_P[i], BX_P[i], r, o, f, m);
    endtask

    task automatic do_reset();
        step(1'b1, OP_R, 3'd0, 7'd0, 1'b0, 1'b1);
        step(1'b1, OP_R, 3'd0, 7'd0, 1'b0, 1'b1);
    endtask

    int exp_r   [5]  = '{0, 1, 6, 8, 0};
    int lw_mr   [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    int lw_st   [10] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4};
    int lw_irw  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [6:0] alu_op_t [7] = '{OP_R, OP_I, OP_R, OP_R, OP_R, OP_I, OP_R};
    logic [2:0] alu_f3_t [7] = '{3'd0, 3'd0, 3'd2, 3'd6, 3'd7, 3'd6, 3'd4};
    logic [6:0] alu_f7_t [7] = '{7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
    int         alu_ex_t [7] = '{1, 0, 5, 3, 2, 3, 0};
    logic [6:0] cpi_op_t [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
    int         cpi_ex_t [6] = '{5, 4, 4, 4, 3, 4};

    initial begin
        int rw_cnt, rt_cnt, n, trap_cnt, pick;
        logic [6:0] op_c;
        logic [2:0] f3_c;
        logic [6:0] f7_c;

        // reset state
        do_reset();
        chk("reset state", int'(st[0]), 0);
        chk("reset PCWrite", int'(pcw[0]), 0);
        chk("reset IRWrite", int'(irw[0]), 0);
        chk("reset illegal", int'(ill[0]), 0);

        // R-type add
        rw_cnt = 0; rt_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, OP_R, 3'd0, 7'd0, 1'b0, 1'b1);
            chk("add state seq", int'(st[0]), exp_r[k]);
            if (st[0] == 4'd6) chk("add ALUControl", int'(aluc[0]), 0);
            chk("add RegWrite only in ALUWB", int'(rgw[0]), (k == 3) ? 1 : 0);
            rt_cnt += int'(ret[0]);
        end
        chk("add retire count", rt_cnt, 1);

        // lw with memory stalls
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, OP_LW, 3'd2, 7'd0, 1'b0, lw_mr[k][0]);
            chk("lw state seq", int'(st[0]), lw_st[k]);
            chk("lw IRWrite", int'(irw[0]), lw_irw[k]);
        end
        chk("lw MEMWB RegWrite", int'(rgw[0]), 1);
        chk("lw MEMWB ResultSrc", int'(rs[0]), 1);
        chk("lw MEMWB retire", int'(ret[0]), 1);

        // branches: beq taken/not taken, bne on both builds
        do_reset();
        repeat (3) step(1'b0, OP_BR, 3'd0, 7'd0, 1'b1, 1'b1);
        chk("beq Z=1 state", int'(st[0]), 9);
        chk("beq Z=1 PCWrite", int'(pcw[0]), 1);
        do_reset();
        repeat (3) step(1'b0, OP_BR, 3'd0, 7'd0, 1'b0, 1'b1);
        chk("beq Z=0 PCWrite", int'(pcw[0]), 0);
        do_reset();
        repeat (3) step(1'b0, OP_BR, 3'd1, 7'd0, 1'b0, 1'b1);
        chk("bne ext state", int'(st[1]), 9);
        chk("bne ext Z=0 PCWrite", int'(pcw[1]), 1);
        chk("bne no-ext trap", int'(st[0]), 11);
        do_reset();
        repeat (3) step(1'b0, OP_BR, 3'd1, 7'd0, 1'b1, 1'b1);
        chk("bne ext Z=1 PCWrite", int'(pcw[1]), 0);

        // illegal opcode traps until reset
        do_reset();
        repeat (3) step(1'b0, OP_SYS, 3'd0, 7'd0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            chk("trap state", int'(st[0]), 11);
            chk("trap illegal", int'(ill[0]), 1);
            step(1'b0, OP_SYS, 3'd0, 7'd0, 1'b0, 1'b1);
        end
        step(1'b1, OP_SYS, 3'd0, 7'd0, 1'b0, 1'b1);
        chk("trap illegal in rst", int'(ill[0]), 0);
        step(1'b0, OP_R, 3'd0, 7'd0, 1'b0, 1'b0);
        chk("post-trap state", int'(st[0]), 0);
        chk("post-trap illegal", int'(ill[0]), 0);

        // sw interrupted by reset in MEMWRITE
        do_reset();
        repeat (3) step(1'b0, OP_SW, 3'd2, 7'd0, 1'b0, 1'b1);
        step(1'b0, OP_SW, 3'd2, 7'd0, 1'b0, 1'b0);
        chk("sw MEMWRITE state", int'(st[0]), 5);
        chk("sw MemWrite", int'(mwr[0]), 1);
        chk("sw no retire while held", int'(ret[0]), 0);
        step(1'b0, OP_SW, 3'd2, 7'd0, 1'b0, 1'b0);
        chk("sw MemWrite held", int'(mwr[0]), 1);
        step(1'b1, OP_SW, 3'd2, 7'd0, 1'b0, 1'b1);
        chk("sw MemWrite in rst", int'(mwr[0]), 0);
        chk("sw retire in rst", int'(ret[0]), 0);
        step(1'b0, OP_SW, 3'd2, 7'd0, 1'b0, 1'b1);
        chk("sw after rst state", int'(st[0]), 0);
        chk("sw after rst retire", int'(ret[0]), 0);

        // ALU decode
        for (int t = 0; t < 7; t++) begin
            do_reset();
            repeat (3) step(1'b0, alu_op_t[t], alu_f3_t[t], alu_f7_t[t], 1'b0, 1'b1);
            chk("alu exec state", int'(st[0]), (alu_op_t[t] == OP_R) ? 6 : 7);
            chk("alu ALUControl", int'(aluc[0]), alu_ex_t[t]);
        end

        // CPI with MEM_WAIT=0 (mem_ready held low)
        for (int t = 0; t < 6; t++) begin
            do_reset();
            step(1'b0, cpi_op_t[t], 3'd0, 7'd0, 1'b1, 1'b0);
            n = 1;
            while (n < 20) begin
                step(1'b0, cpi_op_t[t], 3'd0, 7'd0, 1'b1, 1'b0);
                if (st[1] == 4'd0) break;
                n++;
            end
            chk("no-wait CPI", n, cpi_ex_t[t]);
        end

        // randomized traffic against the model
        op_c = OP_R; f3_c = 3'd0; f7_c = 7'd0; trap_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                pick = int'($urandom_range(0, 15));
                case (pick)
                    0, 1:   op_c = OP_LW;
                    2, 3:   op_c = OP_SW;
                    4, 5:   op_c = OP_R;
                    6, 7:   op_c = OP_I;
                    8, 9:   op_c = OP_BR;
                    10, 11: op_c = OP_JAL;
                    12:     op_c = OP_SYS;
                    13:     op_c = 7'($urandom);
                    default: op_c = OP_R;
                endcase
                f3_c = 3'($urandom_range(0, 7));
                if (op_c == OP_BR && $urandom_range(0, 1) == 1) f3_c = 3'($urandom_range(0, 1));
                f7_c = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 1) << 5);
            end
            step(($urandom_range(0, 59) == 0) || trap_cnt > 8, op_c, f3_c, f7_c,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            trap_cnt = (m_st[0] == 11 || m_st[1] == 11) ? trap_cnt + 1 : 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
